// File: rtl/fft_twiddle_addr_gen.sv
// Radix-2 FFT stage sequencer: walks the N/2 butterflies of one stage, emitting twiddle index and operand addresses.
// Latency: first output valid one cycle after an accepted start; one butterfly per cycle while out_ready is high.
// Backpressure: out_ready low holds every output stable and freezes the butterfly counter.
module fft_twiddle_addr_gen #(
  parameter int LOG2N   = 8,
  parameter int STAGE_W = $clog2(LOG2N),
  parameter int ADDR_W  = LOG2N,
  parameter int IDX_W   = LOG2N - 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic [STAGE_W-1:0] stage,
  input  logic               mode,
  input  logic               clear,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [IDX_W-1:0]   tw_index,
  output logic [ADDR_W-1:0]  addr_a,
  output logic [ADDR_W-1:0]  addr_b,
  output logic               last,
  output logic               busy,
  output logic               stage_done,
  output logic               err
);

  // Span exponent needs one extra bit so that p+1 never wraps.
  localparam int P_W = STAGE_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Registered output bundle.
  typedef struct packed {
    logic              vld;
    logic              lst;
    logic              bsy;
    logic              done;
    logic              err;
    logic [IDX_W-1:0]  tw;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
  } out_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   b_q, b_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic               mode_q, mode_d;
  logic               err_d;
  logic               stage_ok;
  out_t               out_q, out_d;

  // Address arithmetic temporaries, all evaluated on the next-state values.
  logic [P_W-1:0]     p;
  logic [P_W-1:0]     tw_sh;
  logic [ADDR_W-1:0]  b_ext;
  logic [ADDR_W-1:0]  mask;
  logic [ADDR_W-1:0]  k;
  logic [ADDR_W-1:0]  g;
  logic [ADDR_W-1:0]  a_c;

  // Stage numbers LOG2N and above are rejected; LOG2N-1 always fits STAGE_W bits.
  assign stage_ok = (stage <= STAGE_W'(LOG2N - 1));

  // State, counter, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      stage_q <= '0;
      mode_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      stage_q <= stage_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
    end
  end

  // Next state: clear dominates, then start acceptance, handshake-driven stepping, and the one-cycle DONE.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    stage_d = stage_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      b_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (stage_ok) begin
              state_d = S_RUN;
              b_d     = '0;
              stage_d = stage;
              mode_d  = mode;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_RUN: begin
          // out_valid is high for the whole of RUN, so ready alone marks a transfer.
          if (out_ready) begin
            if (&b_q) begin
              state_d = S_DONE;
              b_d     = '0;
            end else begin
              b_d = b_q + IDX_W'(1);
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output values for the next cycle, derived from the next counter and latched stage/mode.
  always_comb begin
    p     = mode_d ? (P_W'(LOG2N - 1) - {1'b0, stage_d}) : {1'b0, stage_d};
    tw_sh = P_W'(LOG2N - 1) - p;
    b_ext = ADDR_W'(b_d);
    mask  = (ADDR_W'(1) << p) - ADDR_W'(1);
    k     = b_ext & mask;
    g     = b_ext >> p;
    a_c   = (g << (p + P_W'(1))) | k;

    out_d      = '0;
    out_d.done = (state_d == S_DONE);
    out_d.err  = err_d;
    if (state_d == S_RUN) begin
      out_d.vld = 1'b1;
      out_d.bsy = 1'b1;
      out_d.lst = &b_d;
      out_d.tw  = IDX_W'(k << tw_sh);
      out_d.a   = a_c;
      out_d.b   = a_c + (ADDR_W'(1) << p);
    end
  end

  assign out_valid  = out_q.vld;
  assign tw_index   = out_q.tw;
  assign addr_a     = out_q.a;
  assign addr_b     = out_q.b;
  assign last       = out_q.lst;
  assign busy       = out_q.bsy;
  assign stage_done = out_q.done;
  assign err        = out_q.err;

endmodule

// File: tb/tb_fft_twiddle_addr_gen.sv
// Directed bench for the FFT stage sequencer at N=8 with a scoreboard of expected butterflies.
// Expected outputs come from a nested group/offset loop model, pushed at start and popped on each transfer.
// Every sampled output cycle is compared, including stalled cycles, against the scoreboard head.
module tb_fft_twiddle_addr_gen;

  localparam int LOG2N   = 3;
  localparam int STAGE_W = $clog2(LOG2N);
  localparam int ADDR_W  = LOG2N;
  localparam int IDX_W   = LOG2N - 1;
  localparam int NPTS    = 1 << LOG2N;
  localparam int HALF    = NPTS / 2;

  logic               clk;
  logic               nrst;
  logic               start;
  logic [STAGE_W-1:0] stage;
  logic               mode;
  logic               clear;
  logic               out_ready;
  logic               out_valid;
  logic [IDX_W-1:0]   tw_index;
  logic [ADDR_W-1:0]  addr_a;
  logic [ADDR_W-1:0]  addr_b;
  logic               last;
  logic               busy;
  logic               stage_done;
  logic               err;

  typedef struct {
    int tw;
    int a;
    int b;
    int lst;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   failures;
  int   xfer_cnt;

  fft_twiddle_addr_gen #(
    .LOG2N  (LOG2N),
    .STAGE_W(STAGE_W),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .stage     (stage),
    .mode      (mode),
    .clear     (clear),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .tw_index  (tw_index),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .last      (last),
    .busy      (busy),
    .stage_done(stage_done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Butterflies of one stage in textbook order: groups of 2h points, offset j inside a group.
  task automatic push_model(input logic m, input int s);
    int p;
    int h;
    int cnt;
    exp_t e;
    p   = m ? (LOG2N - 1 - s) : s;
    h   = 1 << p;
    cnt = 0;
    for (int grp = 0; grp < NPTS; grp += 2 * h) begin
      for (int j = 0; j < h; j++) begin
        e.tw  = j * (HALF / h);
        e.a   = grp + j;
        e.b   = grp + j + h;
        e.lst = (cnt == HALF - 1) ? 1 : 0;
        q.push_back(e);
        cnt++;
      end
    end
  endtask

  // One clock: compare at the falling edge, pop on a transfer, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'(out_valid), 0);
      end else begin
        chk("tw_index", 32'(tw_index), q[0].tw);
        chk("addr_a", 32'(addr_a), q[0].a);
        chk("addr_b", 32'(addr_b), q[0].b);
        chk("last", 32'(last), q[0].lst);
        if (out_ready) begin
          void'(q.pop_front());
          xfer_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_tw"}, 32'(tw_index), 0);
    chk({tag, "_a"}, 32'(addr_a), 0);
    chk({tag, "_b"}, 32'(addr_b), 0);
    chk({tag, "_last"}, 32'(last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(stage_done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  // Full pass; optionally drop out_ready for stall_len cycles once stall_at transfers have completed.
  task automatic run_pass(input logic m, input int s, input int stall_at, input int stall_len);
    int  budget;
    bit  stalled;
    xfer_cnt = 0;
    budget   = 0;
    stalled  = 1'b0;
    push_model(m, s);
    start = 1'b1;
    stage = STAGE_W'(s);
    mode  = m;
    tick();
    start = 1'b0;
    chk("first_valid", 32'(out_valid), 1);
    chk("busy_run", 32'(busy), 1);
    while (q.size() > 0 && budget < 40) begin
      if (!stalled && xfer_cnt == stall_at) begin
        stalled   = 1'b1;
        out_ready = 1'b0;
        repeat (stall_len) begin
          tick();
          chk("stall_valid", 32'(out_valid), 1);
          chk("stall_xfers", xfer_cnt, stall_at);
        end
        out_ready = 1'b1;
      end
      tick();
      budget++;
    end
    chk("pass_timeout", 32'(budget < 40), 1);
    chk("xfers", xfer_cnt, HALF);
    chk("done_pulse", 32'(stage_done), 1);
    chk("valid_after_last", 32'(out_valid), 0);
    tick();
    chk("done_pulse_end", 32'(stage_done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_valid", 32'(out_valid), 0);
    q.delete();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    xfer_cnt  = 0;
    nrst      = 1'b0;
    start     = 1'b0;
    stage     = '0;
    mode      = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;

    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    tick();

    run_pass(1'b0, 0, -1, 0);
    run_pass(1'b0, 1, -1, 0);
    run_pass(1'b0, 2, -1, 0);
    run_pass(1'b1, 0, -1, 0);
    run_pass(1'b1, 1, -1, 0);
    run_pass(1'b1, 2, -1, 0);

    // Backpressure on the second output of DIT stage 2: (1,5) with index 1 must hold.
    run_pass(1'b0, 2, 1, 3);

    // Abort on the third output cycle.
    xfer_cnt = 0;
    push_model(1'b0, 1);
    start = 1'b1;
    stage = STAGE_W'(1);
    mode  = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("abort_pre_xfers", xfer_cnt, 2);
    chk("abort_pre_a", 32'(addr_a), 4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_last", 32'(last), 0);
    chk("abort_done", 32'(stage_done), 0);
    q.delete();
    tick();
    chk("abort_done_later", 32'(stage_done), 0);
    chk("abort_idle_valid", 32'(out_valid), 0);

    // Out-of-range stage is rejected with a single err pulse.
    start = 1'b1;
    stage = STAGE_W'(3);
    tick();
    start = 1'b0;
    chk("err_pulse", 32'(err), 1);
    chk("err_busy", 32'(busy), 0);
    chk("err_valid", 32'(out_valid), 0);
    tick();
    chk("err_end", 32'(err), 0);
    chk("err_idle_valid", 32'(out_valid), 0);

    // start together with clear: nothing begins.
    start = 1'b1;
    clear = 1'b1;
    stage = STAGE_W'(0);
    tick();
    start = 1'b0;
    clear = 1'b0;
    chk("startclr_valid", 32'(out_valid), 0);
    chk("startclr_busy", 32'(busy), 0);
    chk("startclr_err", 32'(err), 0);
    tick();
    chk("startclr_valid2", 32'(out_valid), 0);

    // Reset in the middle of a pass, observed before any clock edge.
    xfer_cnt = 0;
    push_model(1'b0, 2);
    start = 1'b1;
    stage = STAGE_W'(2);
    mode  = 1'b0;
    tick();
    start = 1'b0;
    tick();
    chk("midpass_busy", 32'(busy), 1);
    #2;
    nrst = 1'b0;
    #1;
    check_all_zero("async_reset");
    q.delete();
    tick();
    nrst = 1'b1;
    tick();
    check_all_zero("post_reset");

    run_pass(1'b0, 1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
